// File: rtl/id_ex_operand_stage_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU operation codes and the ID/EX bundle.
// The ID/EX struct is sized by these package widths, so the stage parameters must keep their defaults.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_NOR = 4'b0100;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   alu_op;
    logic [REG_W-1:0]  rs_num;
    logic [REG_W-1:0]  rt_num;
    logic [REG_W-1:0]  rd_num;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
  } id_ex_t;

  // A bubble writes nothing, reads nothing and presents ADD to the ALU.
  localparam id_ex_t ID_EX_BUBBLE = '{alu_op: ALU_ADD, default: '0};

  // A later stage supplies the value of register src; r0 is hard-wired and never forwarded.
  function automatic logic fwd_hit(
    input logic             we,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] src
  );
    return we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Single-operand forwarding selector: EX/MEM beats MEM/WB, which beats the registered raw value.
module operand_fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W
) (
  input  logic [REG_W-1:0]  i_src_num,
  input  logic [DATA_W-1:0] i_raw_data,
  input  logic              i_exmem_reg_write,
  input  logic [REG_W-1:0]  i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_W-1:0]  i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_data
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = fwd_hit(i_exmem_reg_write, i_exmem_rd, i_src_num);
  assign w_memwb_hit = fwd_hit(i_memwb_reg_write, i_memwb_rd, i_src_num);

  always_comb begin
    o_data = i_raw_data;
    if (w_exmem_hit) begin
      o_data = i_exmem_result;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use hazard detection.
// Feeds the ALU operation code and operands directly; forwarded operands are combinational.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int OP_W   = mips_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [REG_W-1:0]  id_rs_num,
  input  logic [REG_W-1:0]  id_rt_num,
  input  logic [REG_W-1:0]  id_rd_num,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              load_use_stall
);

  id_ex_t            r_stage;
  id_ex_t            w_capture;
  logic              w_rs_wb_hit;
  logic              w_rt_wb_hit;
  logic [REG_W-1:0]  w_src_num  [2];
  logic [DATA_W-1:0] w_raw_data [2];
  logic [DATA_W-1:0] w_fwd_data [2];
  logic              w_rs_dep;
  logic              w_rt_dep;

  always_comb begin
    w_capture = ID_EX_BUBBLE;
    if (id_valid) begin
      w_capture.valid     = 1'b1;
      w_capture.alu_op    = id_alu_op;
      w_capture.rs_num    = id_rs_num;
      w_capture.rt_num    = id_rt_num;
      w_capture.rd_num    = id_rd_num;
      w_capture.rs_data   = id_rs_data;
      w_capture.rt_data   = id_rt_data;
      w_capture.imm       = id_imm;
      w_capture.alu_src   = id_alu_src;
      w_capture.reg_write = id_reg_write;
      w_capture.mem_read  = id_mem_read;
    end
  end

  // While held, a write-back to a held source must land in the raw operand or it is lost.
  assign w_rs_wb_hit = fwd_hit(memwb_reg_write, memwb_rd, r_stage.rs_num);
  assign w_rt_wb_hit = fwd_hit(memwb_reg_write, memwb_rd, r_stage.rt_num);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= ID_EX_BUBBLE;
    end else if (flush) begin
      r_stage <= ID_EX_BUBBLE;
    end else if (stall) begin
      if (w_rs_wb_hit) begin
        r_stage.rs_data <= memwb_result;
      end
      if (w_rt_wb_hit) begin
        r_stage.rt_data <= memwb_result;
      end
    end else begin
      r_stage <= w_capture;
    end
  end

  assign w_src_num[0]  = r_stage.rs_num;
  assign w_src_num[1]  = r_stage.rt_num;
  assign w_raw_data[0] = r_stage.rs_data;
  assign w_raw_data[1] = r_stage.rt_data;

  // Index 0 resolves rs, index 1 resolves rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      operand_fwd_mux #(
        .DATA_W(DATA_W),
        .REG_W (REG_W)
      ) u_fwd (
        .i_src_num        (w_src_num[gi]),
        .i_raw_data       (w_raw_data[gi]),
        .i_exmem_reg_write(exmem_reg_write),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_result   (exmem_result),
        .i_memwb_reg_write(memwb_reg_write),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_result   (memwb_result),
        .o_data           (w_fwd_data[gi])
      );
    end
  endgenerate

  assign ex_valid      = r_stage.valid;
  assign ex_alu_op     = r_stage.alu_op;
  assign ex_rd         = r_stage.rd_num;
  assign ex_reg_write  = r_stage.reg_write;
  assign ex_mem_read   = r_stage.mem_read;
  assign ex_a          = w_fwd_data[0];
  assign ex_b          = r_stage.alu_src ? r_stage.imm : w_fwd_data[1];
  assign ex_store_data = w_fwd_data[1];

  // An immediate-form consumer does not read rt, so a load into rt cannot stall it.
  assign w_rs_dep = (r_stage.rd_num == id_rs_num);
  assign w_rt_dep = (r_stage.rd_num == id_rt_num) && !id_alu_src;

  assign load_use_stall = r_stage.valid && r_stage.mem_read && (r_stage.rd_num != '0) &&
                          id_valid && (w_rs_dep || w_rt_dep);

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized scoreboard bench for id_ex_operand_stage against a behavioural pipeline-slot model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, stall, flush;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rs_num, id_rt_num, id_rd_num, exmem_rd, memwb_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic        exmem_reg_write, memwb_reg_write;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num), .id_rd_num(id_rd_num),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .load_use_stall(load_use_stall)
  );

  typedef struct {
    bit        valid, src, rw, mr, stall, flush, xw, ww;
    bit [3:0]  op;
    bit [4:0]  rs, rt, rd, xrd, wrd;
    bit [31:0] rs_d, rt_d, imm, xres, wres;
  } stim_t;

  // What the EX slot holds, in instruction terms.
  typedef struct {
    bit        valid, src, rw, mr;
    bit [3:0]  op;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rs_val, rt_val, imm;
  } slot_t;

  typedef struct {
    bit        valid, rw, mr, lus;
    bit [3:0]  op;
    bit [4:0]  rd;
    bit [31:0] a, b, sd;
  } exp_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  sb[$];
  exp_t  mon_e;
  slot_t m;
  stim_t cur;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom % 4) != 0;
    s.op    = 4'($urandom_range(0, 15));
    s.rs    = 5'($urandom_range(0, 7));
    s.rt    = 5'($urandom_range(0, 7));
    s.rd    = 5'($urandom_range(0, 7));
    s.rs_d  = $urandom;
    s.rt_d  = $urandom;
    s.imm   = $urandom;
    s.src   = 1'($urandom % 2);
    s.rw    = 1'($urandom % 2);
    s.mr    = ($urandom % 3) == 0;
    s.stall = ($urandom % 6) == 0;
    s.flush = ($urandom % 8) == 0;
    s.xw    = 1'($urandom % 2);
    s.xrd   = 5'($urandom_range(0, 7));
    s.xres  = $urandom;
    s.ww    = 1'($urandom % 2);
    s.wrd   = 5'($urandom_range(0, 7));
    s.wres  = $urandom;
    return s;
  endfunction

  // Newest producer of register r wins; r0 is never supplied by a producer.
  function automatic bit [31:0] operand_value(bit [4:0] r, bit [31:0] raw, stim_t s);
    bit [4:0]  who[$];
    bit [31:0] what[$];
    if (s.xw) begin who.push_back(s.xrd); what.push_back(s.xres); end
    if (s.ww) begin who.push_back(s.wrd); what.push_back(s.wres); end
    if (r != 0) begin
      foreach (who[k]) if (who[k] == r) return what[k];
    end
    return raw;
  endfunction

  task automatic model_step(stim_t s);
    if (s.flush || (!s.stall && !s.valid)) begin
      m = '{default: 0};
    end else if (s.stall) begin
      if (s.ww && s.wrd != 0 && s.wrd == m.rs) m.rs_val = s.wres;
      if (s.ww && s.wrd != 0 && s.wrd == m.rt) m.rt_val = s.wres;
    end else begin
      m = '{valid: 1, src: s.src, rw: s.rw, mr: s.mr, op: s.op, rs: s.rs, rt: s.rt,
            rd: s.rd, rs_val: s.rs_d, rt_val: s.rt_d, imm: s.imm};
    end
  endtask

  task automatic drive(stim_t s);
    id_valid = s.valid; id_alu_op = s.op; id_rs_num = s.rs; id_rt_num = s.rt;
    id_rd_num = s.rd; id_rs_data = s.rs_d; id_rt_data = s.rt_d; id_imm = s.imm;
    id_alu_src = s.src; id_reg_write = s.rw; id_mem_read = s.mr;
    stall = s.stall; flush = s.flush;
    exmem_reg_write = s.xw; exmem_rd = s.xrd; exmem_result = s.xres;
    memwb_reg_write = s.ww; memwb_rd = s.wrd; memwb_result = s.wres;
  endtask

  // One clock: the model absorbs what the DUT just captured, then new inputs go out.
  task automatic apply(stim_t s);
    exp_t  e;
    bit [31:0] rt_fwd;
    @(posedge clk);
    model_step(cur);
    #1;
    drive(s);
    cur = s;
    rt_fwd  = operand_value(m.rt, m.rt_val, s);
    e.valid = m.valid; e.op = m.op; e.rw = m.rw; e.mr = m.mr; e.rd = m.rd;
    e.a     = operand_value(m.rs, m.rs_val, s);
    e.b     = m.src ? m.imm : rt_fwd;
    e.sd    = rt_fwd;
    e.lus   = m.valid && m.mr && m.rd != 0 && s.valid &&
              (m.rd == s.rs || (m.rd == s.rt && !s.src));
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("ex_valid", 32'(ex_valid), 32'(mon_e.valid));
      check("ex_alu_op", 32'(ex_alu_op), 32'(mon_e.op));
      check("ex_reg_write", 32'(ex_reg_write), 32'(mon_e.rw));
      check("ex_mem_read", 32'(ex_mem_read), 32'(mon_e.mr));
      check("load_use_stall", 32'(load_use_stall), 32'(mon_e.lus));
      if (mon_e.valid) begin
        check("ex_rd", 32'(ex_rd), 32'(mon_e.rd));
        check("ex_a", ex_a, mon_e.a);
        check("ex_b", ex_b, mon_e.b);
        check("ex_store_data", ex_store_data, mon_e.sd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    cur = idle();
    m = '{default: 0};
    drive(cur);
    #1 reset = 1'b1;
    #1;
    check("reset_ex_valid", 32'(ex_valid), 0);
    check("reset_ex_alu_op", 32'(ex_alu_op), 0);
    check("reset_ex_rd", 32'(ex_rd), 0);
    check("reset_ex_reg_write", 32'(ex_reg_write), 0);
    check("reset_ex_mem_read", 32'(ex_mem_read), 0);
    check("reset_ex_a", ex_a, 0);
    check("reset_ex_b", ex_b, 0);
    check("reset_ex_store_data", ex_store_data, 0);
    check("reset_load_use_stall", 32'(load_use_stall), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset arriving between edges must clear a live instruction at once.
    s = idle(); s.valid = 1; s.op = 4'h1; s.rw = 1; s.rd = 5'd9; s.rs_d = 32'h1234;
    apply(s);
    apply(idle());
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ex_valid", 32'(ex_valid), 0);
    check("async_reset_ex_alu_op", 32'(ex_alu_op), 0);
    check("async_reset_ex_reg_write", 32'(ex_reg_write), 0);
    m = '{default: 0};
    @(posedge clk);
    #1 reset = 1'b0;

    // Plain capture.
    s = idle(); s.valid = 1; s.rs = 1; s.rt = 2; s.rd = 3; s.rs_d = 5; s.rt_d = 7; s.rw = 1;
    apply(s);
    apply(idle());

    // Double hazard on r3, then MEM/WB only, then r0 with both producers targeting r0.
    s = idle(); s.valid = 1; s.rs = 3; s.rs_d = 32'h55; s.rd = 1;
    apply(s);
    s = idle(); s.xw = 1; s.xrd = 3; s.xres = 32'h11; s.ww = 1; s.wrd = 3; s.wres = 32'h22;
    apply(s);
    s = idle(); s.valid = 1; s.rs = 3; s.rs_d = 32'h55; s.rd = 1;
    apply(s);
    s = idle(); s.ww = 1; s.wrd = 3; s.wres = 32'h22;
    apply(s);
    s = idle(); s.valid = 1; s.rs = 0; s.rs_d = 32'h77; s.rd = 1;
    apply(s);
    s = idle(); s.xw = 1; s.xrd = 0; s.xres = 32'h11; s.ww = 1; s.wrd = 0; s.wres = 32'h22;
    apply(s);

    // Load-use via rs, then via rt in immediate form (no stall).
    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.rd = 4;
    apply(s);
    s = idle(); s.valid = 1; s.rs = 4; s.rt = 9;
    apply(s);
    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.rd = 4;
    apply(s);
    s = idle(); s.valid = 1; s.rs = 5; s.rt = 4; s.src = 1;
    apply(s);

    // Write-back to a held source during a stall.
    s = idle(); s.valid = 1; s.rs = 6; s.rs_d = 32'h1; s.rd = 2;
    apply(s);
    s = idle(); s.stall = 1; s.ww = 1; s.wrd = 6; s.wres = 32'h99;
    apply(s);
    apply(idle());

    // Flush wins over stall.
    s = idle(); s.valid = 1; s.rw = 1; s.mr = 1; s.rd = 7;
    apply(s);
    s = idle(); s.stall = 1; s.flush = 1;
    apply(s);
    apply(idle());

    for (int i = 0; i < 1500; i++) apply(rand_stim());
    apply(idle());
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline register and operand-forwarding stage between instruction decode and the 32-bit ALU in the pipelined MIPS core.
- Captures decoded ALU operation, operands and destination register each cycle.
- Resolves EX/MEM and MEM/WB data hazards by forwarding, detects load-use hazards, and drives the ALU operation code and operands A/B directly.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, register-number width.
- OP_W, 4, ALU operation code width.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  OP_W  ALU operation code
- id_rs_num, id_rt_num, id_rd_num  in  REG_W  source and destination register numbers
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_src  in  1  1: B = immediate; 0: B = rt
- id_reg_write, id_mem_read  in  1  destination written / instruction is a load
- stall  in  1  hold stage contents
- flush  in  1  replace stage contents with a bubble
- exmem_reg_write  in  1  forwarding write-enable from EX/MEM
- exmem_rd  in  REG_W  forwarding destination from EX/MEM
- exmem_result  in  DATA_W  forwarding data from EX/MEM
- memwb_reg_write, memwb_rd, memwb_result  in  1/REG_W/DATA_W  same fields from MEM/WB
- ex_valid  out  1  stage holds a real instruction
- ex_alu_op  out  OP_W  to ALU operation input
- ex_a, ex_b  out  DATA_W  to ALU A and B
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_rd  out  REG_W
- ex_reg_write, ex_mem_read  out  1
- load_use_stall  out  1  request to freeze PC and decode

Behaviour:
- Reset (asynchronous, immediate):
  - All registered fields cleared.
  - ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_alu_op=ADD (0), ex_rd=0.
  - Raw operands cleared, so ex_a=ex_b=ex_store_data=0 unless a forwarding match applies.
  - load_use_stall=0.
- Capture: with flush=0 and stall=0, all id_* fields are registered at the rising edge. Latency is exactly 1 cycle from decode to ALU inputs.
- id_valid=0 captures a bubble: reg_write=0, mem_read=0, op=ADD.
- flush=1: bubble captured regardless of stall. flush wins over stall.
- stall=1 and flush=0: contents held. Exception: if memwb_reg_write=1 and memwb_rd matches a held rs/rt (non-zero), the held raw operand is overwritten with memwb_result, so writeback during a stall is not lost.
- Forwarding is combinational on the registered rs/rt numbers, applied separately to the rs and rt operands:
  - EX/MEM hit: exmem_reg_write=1, exmem_rd!=0, exmem_rd==src → exmem_result.
  - Otherwise MEM/WB hit (same rules) → memwb_result.
  - Otherwise the registered raw value.
  - EX/MEM has priority when both hit.
  - Register 0 is never forwarded. Raw value for r0 is whatever was captured (normally 0).
- Operand routing:
  - ex_a = forwarded rs.
  - ex_b = registered immediate if alu_src=1, else forwarded rt.
  - ex_store_data = forwarded rt always.
- load_use_stall (combinational) = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs_num | (ex_rd==id_rt_num & !id_alu_src)).
  - The upstream hazard unit converts this into flush=1 for this stage, plus holding PC/IF/ID for one cycle.
  - The stage does not self-flush.
- Outputs change only on clock or reset, except the forwarding-dependent ex_a/ex_b/ex_store_data and load_use_stall.
- Operation codes outside ADD/SUB/AND/OR/NOR are passed through unmodified.

Decomposition:
- Shared package mips_pkg:
  - ALU op localparams: ADD=4'b0000, SUB=4'b0001, AND=4'b0010, OR=4'b0011, NOR=4'b0100.
  - Widths DATA_W/REG_W/OP_W.
  - Packed struct for the ID/EX bundle, including a bubble constant.
- One sub-module, operand_fwd_mux: a single-operand forwarding selector, instantiated twice (rs, rt).

Test Plan:
- Reset mid-stream: load valid ADD, assert reset between clock edges → ex_valid=0, ex_alu_op=0 immediately, with no clock edge needed.
- Plain capture: id ADD, rs_data=5, rt_data=7, alu_src=0, no forwarding → next cycle ex_a=5, ex_b=7, ex_alu_op=0.
- Double hazard: registered rs=r3, exmem_rd=3 result 0x11, memwb_rd=3 result 0x22, both write → ex_a=0x11. Drop exmem_reg_write → ex_a=0x22. Set rs=r0 with both rd=0 → raw value.
- Load-use: ex holds a load to r4, id reads rs=r4 → load_use_stall=1. Same with id rt=r4 and alu_src=1 → load_use_stall=0.
- Stall with writeback: stall=1 holding rs=r6 raw=1, memwb writes r6=0x99 → after edge and release, raw holds 0x99.
- Flush vs stall: stall=1, flush=1 simultaneously → next cycle ex_valid=0, ex_reg_write=0, ex_mem_read=0.
